// File: rtl/modem_pkg.sv
// modem_pkg: constants and state type shared across the QPSK/16QAM modulation path
package modem_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PILOT = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_GUARD = 2'd3;
    localparam logic MOD_QPSK  = 1'b0;
    localparam logic MOD_16QAM = 1'b1;
    localparam int SYM_WIDTH = 4;
    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_PILOT = ST_PILOT,
        S_DATA  = ST_DATA,
        S_GUARD = ST_GUARD
    } state_e;
endpackage

// File: rtl/sym_mask.sv
// sym_mask: restricts a symbol to the active constellation bits (QPSK keeps only [1:0])
module sym_mask
    import modem_pkg::*;
(
    input  logic                 mod_type,
    input  logic [SYM_WIDTH-1:0] sym_in,
    output logic [SYM_WIDTH-1:0] sym_out
);
    assign sym_out = (mod_type == MOD_16QAM) ? sym_in : {2'b00, sym_in[1:0]};
endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler: emits pilot preamble, payload and zero guard per frame, one symbol per clk_symbol.
// Define FRAME_SCHED_FRAME_CNT_EN to add the 16-bit completed-frame counter output frame_cnt.
module frame_scheduler
    import modem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 6,
    parameter int PILOT_LEN   = 64,
    parameter int PAYLOAD_LEN = 256,
    parameter int GUARD_LEN   = 8,
    parameter int CNT_WIDTH   = 10
) (
    input  logic                  clk_symbol,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  abort,
    input  logic                  mod_type,
    output logic [ADDR_WIDTH-1:0] pilot_addr,
    input  logic [SYM_WIDTH-1:0]  pilot_data,
    output logic                  data_req,
    input  logic                  data_valid,
    input  logic [SYM_WIDTH-1:0]  data_in,
    output logic [SYM_WIDTH-1:0]  sym_out,
    output logic                  sym_valid,
    output logic                  mod_active,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  underflow
`ifdef FRAME_SCHED_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_cnt
`endif
);
    localparam logic [CNT_WIDTH-1:0] P_LAST = CNT_WIDTH'(PILOT_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] D_LAST = CNT_WIDTH'(PAYLOAD_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] G_LAST = CNT_WIDTH'(GUARD_LEN > 0 ? GUARD_LEN - 1 : 0);
    localparam bit HAS_GUARD = GUARD_LEN > 0;

    state_e state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [SYM_WIDTH-1:0] sym_q, sym_d, pilot_sym, data_sym;
    logic valid_q, valid_d, mod_q, mod_d, done_q, done_d, uf_q, uf_d, frame_end;

    // Both paths mask with the latched type so pilot and payload share one constellation.
    sym_mask u_pilot_mask (.mod_type(mod_q), .sym_in(pilot_data), .sym_out(pilot_sym));
    sym_mask u_data_mask  (.mod_type(mod_q), .sym_in(data_in),    .sym_out(data_sym));

    assign frame_end = (state_q == S_DATA && cnt_q == D_LAST && !HAS_GUARD) ||
                       (state_q == S_GUARD && cnt_q == G_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        sym_d   = '0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        mod_d   = mod_q;
        uf_d    = uf_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_PILOT;
                    mod_d   = mod_type;
                    uf_d    = 1'b0;
                end
            end
            S_PILOT: begin
                valid_d = 1'b1;
                sym_d   = pilot_sym;
                if (cnt_q == P_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                valid_d = 1'b1;
                sym_d   = data_valid ? data_sym : '0;
                uf_d    = uf_q | ~data_valid;
                if (cnt_q == D_LAST) begin
                    state_d = S_GUARD;
                    cnt_d   = '0;
                end
            end
            S_GUARD: valid_d = 1'b1;
        endcase
        if (frame_end) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = continuous ? S_PILOT : S_IDLE;
            if (continuous) begin
                mod_d = mod_type;
                uf_d  = 1'b0;
            end
        end
        // Abort outranks start and frame end, and leaves the underflow flag as it was.
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            sym_d   = '0;
            valid_d = 1'b0;
            done_d  = 1'b0;
            mod_d   = mod_q;
            uf_d    = uf_q;
        end
    end

    always_ff @(posedge clk_symbol or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sym_q   <= '0;
            valid_q <= 1'b0;
            mod_q   <= 1'b0;
            done_q  <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            valid_q <= valid_d;
            mod_q   <= mod_d;
            done_q  <= done_d;
            uf_q    <= uf_d;
        end
    end

`ifdef FRAME_SCHED_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    always_ff @(posedge clk_symbol or negedge rst_n) begin
        if (!rst_n) frame_cnt_q <= '0;
        else if (done_d) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
    assign frame_cnt = frame_cnt_q;
`endif

    assign pilot_addr = (state_q == S_PILOT) ? cnt_q[ADDR_WIDTH-1:0] : '0;
    assign data_req   = state_q == S_DATA;
    assign busy       = state_q != S_IDLE;
    assign sym_out    = sym_q;
    assign sym_valid  = valid_q;
    assign mod_active = mod_q;
    assign frame_done = done_q;
    assign underflow  = uf_q;
endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: randomized frame scenarios checked against a symbol-list model of each frame.
module tb_frame_scheduler;
    localparam int P = 4, D = 6, G = 2, FL = P + D + G, FLC = P + D;

    logic clk = 0, rst_n = 1, start = 0, start_c = 0, continuous = 0, abort = 0, mod_type = 0, data_valid = 0;
    logic [3:0] data_in = 0;
    logic [5:0] pa, pa_c;
    logic [3:0] pd, pd_c, so, so_c;
    logic dr, dr_c, sv, sv_c, ma, ma_c, bz, bz_c, fd, fd_c, uf, uf_c;
`ifdef FRAME_SCHED_FRAME_CNT_EN
    logic [15:0] fc, fc_c;
`endif

    logic [3:0] rom [64];
    logic [3:0] d_in [64];
    logic       d_vld [64];
    logic       f_mod [8];
    logic [3:0] r_sym [64];
    logic [5:0] r_addr [64];
    logic       r_val [64], r_done [64], r_busy [64], r_mod [64], r_uf [64], r_req [64];
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;
    assign pd   = rom[pa];
    assign pd_c = rom[pa_c];

    frame_scheduler #(.ADDR_WIDTH(6), .PILOT_LEN(P), .PAYLOAD_LEN(D), .GUARD_LEN(G), .CNT_WIDTH(10)) dut (
        .clk_symbol(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .abort(abort),
        .mod_type(mod_type), .pilot_addr(pa), .pilot_data(pd), .data_req(dr), .data_valid(data_valid),
        .data_in(data_in), .sym_out(so), .sym_valid(sv), .mod_active(ma), .busy(bz),
        .frame_done(fd), .underflow(uf)
`ifdef FRAME_SCHED_FRAME_CNT_EN
        , .frame_cnt(fc)
`endif
    );

    frame_scheduler #(.ADDR_WIDTH(6), .PILOT_LEN(P), .PAYLOAD_LEN(D), .GUARD_LEN(0), .CNT_WIDTH(10)) dut_c (
        .clk_symbol(clk), .rst_n(rst_n), .start(start_c), .continuous(continuous), .abort(abort),
        .mod_type(mod_type), .pilot_addr(pa_c), .pilot_data(pd_c), .data_req(dr_c), .data_valid(data_valid),
        .data_in(data_in), .sym_out(so_c), .sym_valid(sv_c), .mod_active(ma_c), .busy(bz_c),
        .frame_done(fd_c), .underflow(uf_c)
`ifdef FRAME_SCHED_FRAME_CNT_EN
        , .frame_cnt(fc_c)
`endif
    );

    function automatic logic [3:0] mask(input logic m, input logic [3:0] s);
        return m ? s : {2'b00, s[1:0]};
    endfunction

    // Symbol p of frame f: pilots from the ROM, payload from the source (0 if missing), then zeros.
    function automatic logic [3:0] expect_sym(input int f, input int p);
        int j;
        j = f * D + p - P;
        if (p < P) return mask(f_mod[f], rom[p]);
        if (p < P + D) return d_vld[j] ? mask(f_mod[f], d_in[j]) : 4'h0;
        return 4'h0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Records n cycles of outputs and drives source data, chaining and mod_type by frame position.
    task automatic capture(input bit sel, input int n, input int fl, input int nfr, input bit tog);
        for (int c = 0; c < n; c++) begin
            int p, j;
            tick();
            r_sym[c]  = sel ? so_c : so;
            r_val[c]  = sel ? sv_c : sv;
            r_done[c] = sel ? fd_c : fd;
            r_busy[c] = sel ? bz_c : bz;
            r_mod[c]  = sel ? ma_c : ma;
            r_uf[c]   = sel ? uf_c : uf;
            r_req[c]  = sel ? dr_c : dr;
            r_addr[c] = sel ? pa_c : pa;
            start = 0;
            start_c = 0;
            p = c % fl;
            j = (c / fl) * D + p - P;
            data_valid = (p >= P && p < P + D && c / fl < nfr) ? d_vld[j] : 1'b0;
            data_in    = (p >= P && p < P + D && c / fl < nfr) ? d_in[j] : 4'h0;
            continuous = (c / fl) < nfr - 1;
            mod_type   = tog ? 1'($urandom) : f_mod[(c + 1) / fl];
        end
    endtask

    task automatic test_reset;
        #1 rst_n = 0;
        #2;
        vectors++;
        if ({so, sv, ma, fd, uf, pa, dr, bz} !== 16'h0 || {so_c, sv_c, ma_c, fd_c, uf_c, pa_c, dr_c, bz_c} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset: got sym=%h v=%b mod=%b done=%b uf=%b addr=%0d req=%b busy=%b, want all 0", so, sv, ma, fd, uf, pa, dr, bz);
        end
`ifdef FRAME_SCHED_FRAME_CNT_EN
        vectors++;
        if (fc !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_frame_cnt: got %0d want 0", fc);
        end
`endif
        tick();
        tick();
        #2 rst_n = 1;
    endtask

    // mode 0: ROM F / data A, all valid; mode 1: same with payload symbol 3 missing; mode 2: random
    task automatic test_frame(input logic m, input bit tog, input int mode);
        logic ufe;
        ufe = 0;
        f_mod[0] = m;
        for (int i = 0; i < 64; i++) begin
            rom[i]   = mode == 2 ? 4'($urandom) : 4'hF;
            d_in[i]  = mode == 2 ? 4'($urandom) : 4'hA;
            d_vld[i] = mode == 2 ? ($urandom_range(7) != 0) : !(mode == 1 && i == 3);
        end
        mod_type = m;
        start = 1;
        capture(0, FL + 2, FL, 1, tog);
        for (int k = 0; k < FL + 2; k++) begin
            logic [3:0] es;
            logic [5:0] ea;
            logic ev, ed, eb, er;
            if (k >= 1 && k - 1 >= P && k - 1 < P + D && !d_vld[k - 1 - P]) ufe = 1;
            es = (k >= 1 && k <= FL) ? expect_sym(0, k - 1) : 4'h0;
            ev = k >= 1 && k <= FL;
            ed = k == FL;
            eb = k < FL;
            er = k >= P && k < P + D;
            ea = k < P ? 6'(k) : 6'd0;
            vectors++;
            if ({r_sym[k], r_val[k], r_done[k], r_busy[k], r_mod[k], r_uf[k], r_req[k], r_addr[k]} !== {es, ev, ed, eb, m, ufe, er, ea}) begin
                miscompares++;
                $display("FAIL frame(mod=%0d mode=%0d) k=%0d: got sym=%h v=%b done=%b busy=%b mod=%b uf=%b req=%b addr=%0d, want sym=%h v=%b done=%b busy=%b mod=%b uf=%b req=%b addr=%0d",
                         m, mode, k, r_sym[k], r_val[k], r_done[k], r_busy[k], r_mod[k], r_uf[k], r_req[k], r_addr[k], es, ev, ed, eb, m, ufe, er, ea);
            end
        end
    endtask

    task automatic test_abort;
        mod_type = 1;
        start = 1;
        abort = 1;
        tick();
        vectors++;
        if ({bz, sv, uf} !== 3'b001) begin
            miscompares++;
            $display("FAIL abort_beats_start: got busy=%b v=%b uf=%b, want busy=0 v=0 uf=1", bz, sv, uf);
        end
        abort = 0;
        tick();
        vectors++;
        if ({bz, pa, uf} !== {1'b1, 6'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL abort_start: got busy=%b addr=%0d uf=%b, want busy=1 addr=0 uf=0", bz, pa, uf);
        end
        tick();
        tick();
        vectors++;
        if (pa !== 6'd2) begin
            miscompares++;
            $display("FAIL abort_pilot2: got addr=%0d want 2", pa);
        end
        abort = 1;
        tick();
        vectors++;
        if ({bz, sv, so, fd, pa} !== 13'h0) begin
            miscompares++;
            $display("FAIL abort_idle: got busy=%b v=%b sym=%h done=%b addr=%0d, want all 0", bz, sv, so, fd, pa);
        end
        abort = 0;
        tick();
        vectors++;
        if ({bz, sv, fd, pa} !== {1'b1, 1'b0, 1'b0, 6'd0}) begin
            miscompares++;
            $display("FAIL abort_restart: got busy=%b v=%b done=%b addr=%0d, want busy=1 v=0 done=0 addr=0", bz, sv, fd, pa);
        end
        start = 0;
        tick();
        vectors++;
        if ({sv, so, ma} !== {1'b1, rom[0], 1'b1}) begin
            miscompares++;
            $display("FAIL abort_first_sym: got v=%b sym=%h mod=%b, want v=1 sym=%h mod=1", sv, so, ma, rom[0]);
        end
        abort = 1;
        tick();
        abort = 0;
        vectors++;
        if (bz !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_cleanup: got busy=%b want 0", bz);
        end
    endtask

    task automatic test_continuous;
        for (int i = 0; i < 8; i++) f_mod[i] = 1'($urandom);
        for (int i = 0; i < 64; i++) begin
            rom[i]   = 4'($urandom);
            d_in[i]  = 4'($urandom);
            d_vld[i] = 1'b1;
        end
        mod_type = f_mod[0];
        start_c = 1;
        capture(1, 3 * FLC + 2, FLC, 3, 0);
        for (int k = 0; k < 3 * FLC + 2; k++) begin
            logic [3:0] es;
            logic [5:0] ea;
            logic ev, ed, eb, er, em;
            ev = k >= 1 && k <= 3 * FLC;
            es = ev ? expect_sym((k - 1) / FLC, (k - 1) % FLC) : 4'h0;
            ed = ev && k % FLC == 0;
            eb = k < 3 * FLC;
            em = eb ? f_mod[k / FLC] : f_mod[2];
            er = eb && k % FLC >= P;
            ea = (eb && k % FLC < P) ? 6'(k % FLC) : 6'd0;
            vectors++;
            if ({r_sym[k], r_val[k], r_done[k], r_busy[k], r_mod[k], r_uf[k], r_req[k], r_addr[k]} !== {es, ev, ed, eb, em, 1'b0, er, ea}) begin
                miscompares++;
                $display("FAIL continuous k=%0d: got sym=%h v=%b done=%b busy=%b mod=%b uf=%b req=%b addr=%0d, want sym=%h v=%b done=%b busy=%b mod=%b uf=0 req=%b addr=%0d",
                         k, r_sym[k], r_val[k], r_done[k], r_busy[k], r_mod[k], r_uf[k], r_req[k], r_addr[k], es, ev, ed, eb, em, er, ea);
            end
        end
`ifdef FRAME_SCHED_FRAME_CNT_EN
        vectors++;
        if (fc_c !== 16'd3) begin
            miscompares++;
            $display("FAIL frame_cnt: got %0d want 3", fc_c);
        end
`endif
    endtask

    task automatic test_reset_mid;
        mod_type = 1;
        start = 1;
        tick();
        start = 0;
        repeat (P + 2) tick();
        vectors++;
        if (dr !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_in_data: got req=%b want 1", dr);
        end
        #1 rst_n = 0;
        #1;
        vectors++;
        if ({so, sv, ma, fd, uf, pa, dr, bz} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mid: got sym=%h v=%b mod=%b done=%b uf=%b addr=%0d req=%b busy=%b, want all 0", so, sv, ma, fd, uf, pa, dr, bz);
        end
`ifdef FRAME_SCHED_FRAME_CNT_EN
        vectors++;
        if (fc !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_mid_frame_cnt: got %0d want 0", fc);
        end
`endif
        #1 rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_frame(1'b0, 1'b0, 0);
        test_frame(1'b1, 1'b1, 0);
        test_frame(1'b0, 1'b0, 1);
        test_abort();
        test_continuous();
        for (int i = 0; i < 4; i++) test_frame(1'($urandom), 1'b0, 2);
        test_reset_mid();
        test_frame(1'($urandom), 1'b0, 2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
Per-frame sequencer for the QPSK/16QAM modulation path. It emits each frame as a pilot preamble, then a payload of source data symbols, then an optional zero guard interval, at one symbol per clk_symbol. It drives the pilot ROM address and the data-request strobe. It freezes the modulation type for the whole frame, so that pilot and data symbols always use the same constellation.

Parameters:
ADDR_WIDTH, 6, pilot ROM address width; requires PILOT_LEN <= 2**ADDR_WIDTH
PILOT_LEN, 64, pilot symbols per frame, >= 1
PAYLOAD_LEN, 256, data symbols per frame, >= 1
GUARD_LEN, 8, zero symbols after the payload, >= 0
CNT_WIDTH, 10, symbol counter width; must hold max(PILOT_LEN, PAYLOAD_LEN, GUARD_LEN)

Ports:
clk_symbol  in  1  symbol clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a frame; sampled only in IDLE
continuous  in  1  at frame end: 1 = chain the next frame, 0 = return to IDLE
abort  in  1  synchronous abort, highest priority
mod_type  in  1  0 = QPSK, 1 = 16QAM; latched at frame start
pilot_addr  out  ADDR_WIDTH  pilot ROM address (combinational from counter)
pilot_data  in  4  pilot ROM output, valid in the same cycle as pilot_addr; QPSK uses bits [1:0]
data_req  out  1  combinational; high in every DATA-state cycle
data_valid  in  1  source has a symbol on data_in this cycle
data_in  in  4  source symbol; QPSK uses bits [1:0]
sym_out  out  4  registered output symbol
sym_valid  out  1  registered; sym_out is meaningful
mod_active  out  1  latched mod_type of the current frame
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse, registered
underflow  out  1  sticky: data_valid was low while data_req was high

Behaviour:
- Reset (async, rst_n = 0): state IDLE, counter 0. sym_out = 0, sym_valid = 0, mod_active = 0, frame_done = 0, underflow = 0. pilot_addr = 0, data_req = 0.
- States: IDLE, PILOT, DATA, GUARD. One counter cnt is cleared on every state entry.
- IDLE:
  - sym_valid <= 0, sym_out <= 0.
  - On start = 1: mod_active <= mod_type, underflow <= 0, go to PILOT.
- PILOT:
  - pilot_addr = cnt[ADDR_WIDTH-1:0].
  - Next edge: sym_out <= (mod_active ? pilot_data : {2'b00, pilot_data[1:0]}), sym_valid <= 1.
  - When cnt == PILOT_LEN-1, go to DATA.
- DATA:
  - data_req = 1.
  - Next edge: sym_out <= masked data_in if data_valid = 1; otherwise sym_out <= 0 and underflow <= 1. sym_valid <= 1 in both cases, because the rate is fixed and there is no stall.
  - When cnt == PAYLOAD_LEN-1, go to GUARD (if GUARD_LEN > 0) or take the frame-end action.
- GUARD:
  - Next edge: sym_out <= 0, sym_valid <= 1.
  - When cnt == GUARD_LEN-1, take the frame-end action.
- Frame end, in the cycle of the frame's last symbol:
  - frame_done <= 1 for one cycle. It is high in the same cycle that sym_out carries the last symbol.
  - If continuous = 1: go to PILOT, relatch mod_active <= mod_type, clear underflow. No idle gap between frames.
  - If continuous = 0: go to IDLE.
- Latency: 1 cycle from pilot_addr/data_req to the matching sym_out.
- Frame length: PILOT_LEN + PAYLOAD_LEN + GUARD_LEN symbols. In single-frame mode, sym_valid is high for exactly that many consecutive cycles.
- start while busy: ignored.
- mod_type changes mid-frame: ignored until the next latch point.
- abort = 1 in any state:
  - Next edge: IDLE, cnt = 0, sym_valid <= 0, sym_out <= 0, no frame_done.
  - abort beats simultaneous start and frame end.
  - underflow is held, not cleared.
- rst_n asserted mid-frame: immediate return to reset values; no partial-frame completion.

Optional Feature:
- Macro: FRAME_SCHED_FRAME_CNT_EN.
- Defined: adds output frame_cnt [15:0].
  - Reset value 0.
  - Increments in the cycle frame_done is asserted; wraps 16'hFFFF -> 0.
  - Not changed by abort.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package, modem_pkg:
  - State encoding localparams ST_IDLE = 2'd0, ST_PILOT = 2'd1, ST_DATA = 2'd2, ST_GUARD = 2'd3.
  - MOD_QPSK = 1'b0, MOD_16QAM = 1'b1.
  - SYM_WIDTH = 4.
- Sub-module: sym_mask (mod_type, sym_in -> sym_out, QPSK zeroes bits [3:2]), reused by the pilot and data paths. The FSM and counter stay in frame_scheduler.

Test Plan:
- Single QPSK frame, PILOT_LEN = 4, PAYLOAD_LEN = 6, GUARD_LEN = 2, ROM returns 4'hF, data_valid = 1, data_in = 4'hA, start pulse:
  - sym_out = 3,3,3,3,2,2,2,2,2,2,0,0.
  - sym_valid high for 12 cycles; frame_done in cycle 12; back to IDLE.
- Same frame in 16QAM with mod_type toggled mid-frame:
  - sym_out = F×4, A×6, 0×2.
  - mod_active stays 1 throughout.
- continuous = 1, three frames, GUARD_LEN = 0:
  - 30 contiguous valid symbols, no gaps.
  - frame_done at symbols 10, 20, 30.
  - With FRAME_SCHED_FRAME_CNT_EN, frame_cnt = 3.
- data_valid = 0 for DATA symbol 3:
  - That symbol is 0, sym_valid stays 1, underflow = 1 until the next start.
- abort in PILOT cycle 2, with start held high:
  - Next cycle: IDLE, sym_valid = 0, no frame_done.
  - Next start begins with pilot_addr = 0.
- rst_n pulsed low mid-DATA:
  - All outputs reset asynchronously.
  - start after release produces a full 12-symbol frame.
